// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter and its two requesters plus the memory array.
// slave = arbiter view, master = requester/memory-environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              i_cpu_req;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              o_cpu_gnt;
  logic              o_cpu_rvalid;
  logic [DATA_W-1:0] o_cpu_rdata;

  logic              i_ext_req;
  logic              i_ext_we;
  logic [ADDR_W-1:0] i_ext_addr;
  logic [DATA_W-1:0] i_ext_wdata;
  logic              o_ext_gnt;
  logic              o_ext_rvalid;
  logic [DATA_W-1:0] o_ext_rdata;

  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [1:0]        o_owner;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
    input  i_ext_req, i_ext_we, i_ext_addr, i_ext_wdata,
    output o_ext_gnt, o_ext_rvalid, o_ext_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata,
    output o_owner
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
    output i_ext_req, i_ext_we, i_ext_addr, i_ext_wdata,
    input  o_ext_gnt, o_ext_rvalid, o_ext_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata,
    input  o_owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU-priority arbiter for one synchronous memory port with a MAX_BURST starvation cap.
// Define MEM_ARB_STATS_EN to add saturating conflict / ext-grant counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]        o_conflict_cnt,
  output logic [15:0]        o_ext_gnt_cnt,
`endif
  mem_port_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_EXT  = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cpu_rtag;
  logic             r_ext_rtag;

  logic w_both;
  logic w_at_cap;
  logic w_cpu_gnt;
  logic w_ext_gnt;
  logic w_cpu_rvalid;
  logic w_ext_rvalid;

  assign w_both   = bus.i_cpu_req & bus.i_ext_req;
  assign w_at_cap = (r_cnt >= CNT_W'(MAX_BURST));

  // Grant decision; the owner keeps the port under contention until its burst hits the cap
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_ext_gnt = 1'b0;
    if (!i_rst) begin
      if (w_both) begin
        case (r_state)
          ST_CPU: begin
            w_cpu_gnt = !w_at_cap;
            w_ext_gnt = w_at_cap;
          end
          ST_EXT: begin
            w_ext_gnt = !w_at_cap;
            w_cpu_gnt = w_at_cap;
          end
          default: w_cpu_gnt = 1'b1;
        endcase
      end else begin
        w_cpu_gnt = bus.i_cpu_req;
        w_ext_gnt = bus.i_ext_req;
      end
    end
  end

  assign bus.o_cpu_gnt   = w_cpu_gnt;
  assign bus.o_ext_gnt   = w_ext_gnt;
  assign bus.o_mem_en    = w_cpu_gnt | w_ext_gnt;
  assign bus.o_mem_we    = (w_cpu_gnt & bus.i_cpu_we) | (w_ext_gnt & bus.i_ext_we);
  assign bus.o_mem_addr  = w_cpu_gnt ? bus.i_cpu_addr  : (w_ext_gnt ? bus.i_ext_addr  : '0);
  assign bus.o_mem_wdata = w_cpu_gnt ? bus.i_cpu_wdata : (w_ext_gnt ? bus.i_ext_wdata : '0);

  // Owner state, saturating burst counter and one-cycle read-return tags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cpu_rtag <= 1'b0;
      r_ext_rtag <= 1'b0;
    end else begin
      r_cpu_rtag <= w_cpu_gnt & ~bus.i_cpu_we;
      r_ext_rtag <= w_ext_gnt & ~bus.i_ext_we;
      if (w_cpu_gnt) begin
        r_state <= ST_CPU;
        if (r_state != ST_CPU) r_cnt <= CNT_W'(1);
        else if (!w_at_cap)    r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_ext_gnt) begin
        r_state <= ST_EXT;
        if (r_state != ST_EXT) r_cnt <= CNT_W'(1);
        else if (!w_at_cap)    r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end
    end
  end

  // A reset arriving while a read is in flight suppresses its return immediately
  assign w_cpu_rvalid     = r_cpu_rtag & ~i_rst;
  assign w_ext_rvalid     = r_ext_rtag & ~i_rst;
  assign bus.o_cpu_rvalid = w_cpu_rvalid;
  assign bus.o_ext_rvalid = w_ext_rvalid;
  assign bus.o_cpu_rdata  = w_cpu_rvalid ? bus.i_mem_rdata : '0;
  assign bus.o_ext_rdata  = w_ext_rvalid ? bus.i_mem_rdata : '0;
  assign bus.o_owner      = r_state;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;
  logic [15:0] r_ext_gnt_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_conflict_cnt <= '0;
      r_ext_gnt_cnt  <= '0;
    end else begin
      if (w_both && (r_conflict_cnt != 16'hFFFF))   r_conflict_cnt <= r_conflict_cnt + 16'd1;
      if (w_ext_gnt && (r_ext_gnt_cnt != 16'hFFFF)) r_ext_gnt_cnt  <= r_ext_gnt_cnt + 16'd1;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;
  assign o_ext_gnt_cnt  = r_ext_gnt_cnt;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a vector table and
// randomized traffic against a rule-level reference model (instance A: MAX_BURST=4, B: MAX_BURST=1).
module tb_mem_port_arbiter;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int          MB_A = 4;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } side_t;

  typedef struct {
    logic       creq;
    logic       ereq;
    logic       exp_cg;
    logic       exp_eg;
    logic [1:0] exp_own;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] a_conf, a_egc, b_conf, b_egc;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB_A)) u_dut_a (
    .i_clk(clk),
    .i_rst(rst),
`ifdef MEM_ARB_STATS_EN
    .o_conflict_cnt(a_conf),
    .o_ext_gnt_cnt(a_egc),
`endif
    .bus(a_if)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(1)) u_dut_b (
    .i_clk(clk),
    .i_rst(rst),
`ifdef MEM_ARB_STATS_EN
    .o_conflict_cnt(b_conf),
    .o_ext_gnt_cnt(b_egc),
`endif
    .bus(b_if)
  );

  function automatic logic [DW-1:0] init_val(int i);
    case (i)
      'h10:    return 8'hA5;
      'h01:    return 8'h11;
      'h02:    return 8'h22;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  // Synchronous memory arrays: read data appears the cycle after the access
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] a_rd, b_rd;
  assign a_if.i_mem_rdata = a_rd;
  assign b_if.i_mem_rdata = b_rd;

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = init_val(i);
    a_rd = '0;
    forever begin
      @(posedge clk);
      if (a_if.o_mem_en) begin
        if (a_if.o_mem_we) mem_a[a_if.o_mem_addr] = a_if.o_mem_wdata;
        else               a_rd <= mem_a[a_if.o_mem_addr];
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_b[i] = init_val(i);
    b_rd = '0;
    forever begin
      @(posedge clk);
      if (b_if.o_mem_en) begin
        if (b_if.o_mem_we) mem_b[b_if.o_mem_addr] = b_if.o_mem_wdata;
        else               b_rd <= mem_b[b_if.o_mem_addr];
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model for instance A: owner (0 none, 1 cpu, 2 ext), length of current run
  int            m_owner  = 0;
  int            m_streak = 0;
  int            m_conf   = 0;
  int            m_egc    = 0;
  logic [DW-1:0] ref_mem [256];
  logic          exp_cpu_rv = 1'b0, exp_ext_rv = 1'b0;
  logic [DW-1:0] exp_cpu_rd = '0,   exp_ext_rd = '0;

  function automatic int model_grant();
    bit c = a_if.i_cpu_req;
    bit e = a_if.i_ext_req;
    if (rst) return 0;
    if (c && e) begin
      if (m_owner == 0)     return 1;
      if (m_streak < MB_A)  return m_owner;
      return 3 - m_owner;
    end
    if (c) return 1;
    if (e) return 2;
    return 0;
  endfunction

  task automatic tick();
    int g = model_grant();
    exp_cpu_rv = 1'b0; exp_ext_rv = 1'b0;
    exp_cpu_rd = '0;   exp_ext_rd = '0;
    if (rst) begin
      m_owner = 0; m_streak = 0; m_conf = 0; m_egc = 0;
    end else begin
      if (a_if.i_cpu_req && a_if.i_ext_req && m_conf < 65535) m_conf++;
      if (g == 2 && m_egc < 65535) m_egc++;
      if (g == 1) begin
        if (a_if.i_cpu_we) ref_mem[a_if.i_cpu_addr] = a_if.i_cpu_wdata;
        else begin exp_cpu_rv = 1'b1; exp_cpu_rd = ref_mem[a_if.i_cpu_addr]; end
      end
      if (g == 2) begin
        if (a_if.i_ext_we) ref_mem[a_if.i_ext_addr] = a_if.i_ext_wdata;
        else begin exp_ext_rv = 1'b1; exp_ext_rd = ref_mem[a_if.i_ext_addr]; end
      end
      if (g == 0) begin
        m_owner = 0; m_streak = 0;
      end else begin
        m_streak = (g == m_owner) ? ((m_streak < MB_A) ? m_streak + 1 : m_streak) : 1;
        m_owner  = g;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_model();
    int            g = model_grant();
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic          crv, erv;
    ewe = (g == 1) ? a_if.i_cpu_we   : (g == 2) ? a_if.i_ext_we   : 1'b0;
    ea  = (g == 1) ? a_if.i_cpu_addr : (g == 2) ? a_if.i_ext_addr : 8'h00;
    ewd = (g == 1) ? a_if.i_cpu_wdata : (g == 2) ? a_if.i_ext_wdata : 8'h00;
    crv = exp_cpu_rv & ~rst;
    erv = exp_ext_rv & ~rst;
    chk("rnd_cpu_gnt",    32'(a_if.o_cpu_gnt),    32'(g == 1));
    chk("rnd_ext_gnt",    32'(a_if.o_ext_gnt),    32'(g == 2));
    chk("rnd_mem_en",     32'(a_if.o_mem_en),     32'(g != 0));
    chk("rnd_mem_we",     32'(a_if.o_mem_we),     32'(ewe));
    chk("rnd_mem_addr",   32'(a_if.o_mem_addr),   32'(ea));
    chk("rnd_mem_wdata",  32'(a_if.o_mem_wdata),  32'(ewd));
    chk("rnd_owner",      32'(a_if.o_owner),      32'(m_owner));
    chk("rnd_cpu_rvalid", 32'(a_if.o_cpu_rvalid), 32'(crv));
    chk("rnd_ext_rvalid", 32'(a_if.o_ext_rvalid), 32'(erv));
    chk("rnd_cpu_rdata",  32'(a_if.o_cpu_rdata),  32'(crv ? exp_cpu_rd : 8'h00));
    chk("rnd_ext_rdata",  32'(a_if.o_ext_rdata),  32'(erv ? exp_ext_rd : 8'h00));
  endtask

  function automatic side_t mk(logic req, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd);
    side_t s;
    s.req = req; s.we = we; s.addr = addr; s.wd = wd;
    return s;
  endfunction

  task automatic drv_a(input side_t c, input side_t e);
    a_if.i_cpu_req = c.req; a_if.i_cpu_we = c.we; a_if.i_cpu_addr = c.addr; a_if.i_cpu_wdata = c.wd;
    a_if.i_ext_req = e.req; a_if.i_ext_we = e.we; a_if.i_ext_addr = e.addr; a_if.i_ext_wdata = e.wd;
  endtask

  task automatic drv_b(input side_t c, input side_t e);
    b_if.i_cpu_req = c.req; b_if.i_cpu_we = c.we; b_if.i_cpu_addr = c.addr; b_if.i_cpu_wdata = c.wd;
    b_if.i_ext_req = e.req; b_if.i_ext_we = e.we; b_if.i_ext_addr = e.addr; b_if.i_ext_wdata = e.wd;
  endtask

  vec_t  tbl [14];
  side_t s0;

  initial begin
    bit            cp, ep, cwe, ewe;
    logic [AW-1:0] caddr, eaddr;
    logic [DW-1:0] cwd, ewd;
    int            g;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    s0 = mk(1'b0, 1'b0, 8'h00, 8'h00);

    // Contention under MAX_BURST=4 from idle, then single-requester and idle transitions
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01};

    rst = 1'b1;
    drv_a(mk(1'b1, 1'b1, 8'hF8, 8'h01), mk(1'b1, 1'b1, 8'hF9, 8'h02));
    drv_b(s0, s0);
    @(negedge clk);

    // Reset held two cycles with both requesting
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rst_cpu_gnt",    32'(a_if.o_cpu_gnt),    32'd0);
      chk("rst_ext_gnt",    32'(a_if.o_ext_gnt),    32'd0);
      chk("rst_mem_en",     32'(a_if.o_mem_en),     32'd0);
      chk("rst_owner",      32'(a_if.o_owner),      32'd0);
      chk("rst_cpu_rvalid", 32'(a_if.o_cpu_rvalid), 32'd0);
      chk("rst_ext_rvalid", 32'(a_if.o_ext_rvalid), 32'd0);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("rel_cpu_gnt", 32'(a_if.o_cpu_gnt), 32'd1);
    chk("rel_ext_gnt", 32'(a_if.o_ext_gnt), 32'd0);
    tick();

    // CPU read alone
    drv_a(mk(1'b1, 1'b0, 8'h10, 8'h00), s0);
    #1;
    chk("crd_gnt",      32'(a_if.o_cpu_gnt),  32'd1);
    chk("crd_mem_en",   32'(a_if.o_mem_en),   32'd1);
    chk("crd_mem_addr", 32'(a_if.o_mem_addr), 32'h10);
    chk("crd_mem_we",   32'(a_if.o_mem_we),   32'd0);
    tick();
    drv_a(s0, s0);
    #1;
    chk("crd_rvalid",     32'(a_if.o_cpu_rvalid), 32'd1);
    chk("crd_rdata",      32'(a_if.o_cpu_rdata),  32'hA5);
    chk("crd_ext_rvalid", 32'(a_if.o_ext_rvalid), 32'd0);
    chk("idle_mem_en",    32'(a_if.o_mem_en),     32'd0);
    chk("idle_mem_addr",  32'(a_if.o_mem_addr),   32'd0);
    chk("idle_mem_wdata", 32'(a_if.o_mem_wdata),  32'd0);
    tick();

    // Ext write alone, then CPU read-back
    drv_a(s0, mk(1'b1, 1'b1, 8'h20, 8'h3C));
    #1;
    chk("ewr_gnt",       32'(a_if.o_ext_gnt),   32'd1);
    chk("ewr_cpu_gnt",   32'(a_if.o_cpu_gnt),   32'd0);
    chk("ewr_mem_we",    32'(a_if.o_mem_we),    32'd1);
    chk("ewr_mem_addr",  32'(a_if.o_mem_addr),  32'h20);
    chk("ewr_mem_wdata", 32'(a_if.o_mem_wdata), 32'h3C);
    tick();
    drv_a(s0, s0);
    #1;
    chk("ewr_no_ext_rvalid", 32'(a_if.o_ext_rvalid), 32'd0);
    chk("ewr_no_cpu_rvalid", 32'(a_if.o_cpu_rvalid), 32'd0);
    chk("ewr_ext_rdata",     32'(a_if.o_ext_rdata),  32'd0);
    tick();
    drv_a(mk(1'b1, 1'b0, 8'h20, 8'h00), s0);
    #1;
    chk("rb_gnt", 32'(a_if.o_cpu_gnt), 32'd1);
    tick();
    drv_a(s0, s0);
    #1;
    chk("rb_rvalid", 32'(a_if.o_cpu_rvalid), 32'd1);
    chk("rb_rdata",  32'(a_if.o_cpu_rdata),  32'h3C);
    tick();

    // Reset arriving the cycle after a CPU read grant
    drv_a(mk(1'b1, 1'b0, 8'h10, 8'h00), s0);
    #1;
    chk("rmr_gnt", 32'(a_if.o_cpu_gnt), 32'd1);
    tick();
    drv_a(s0, s0);
    rst = 1'b1;
    #1;
    chk("rmr_rvalid_in_rst", 32'(a_if.o_cpu_rvalid), 32'd0);
    chk("rmr_rdata_in_rst",  32'(a_if.o_cpu_rdata),  32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rmr_rvalid_after", 32'(a_if.o_cpu_rvalid), 32'd0);
    chk("rmr_owner_after",  32'(a_if.o_owner),      32'd0);
    tick();

    // Vector table: also confirms the burst counter restarted from zero
    for (int i = 0; i < 14; i++) begin
      drv_a(mk(tbl[i].creq, 1'b1, 8'hF0, 8'(i)), mk(tbl[i].ereq, 1'b1, 8'hF1, 8'(i + 64)));
      #1;
      chk($sformatf("tbl%0d_cpu_gnt", i), 32'(a_if.o_cpu_gnt), 32'(tbl[i].exp_cg));
      chk($sformatf("tbl%0d_ext_gnt", i), 32'(a_if.o_ext_gnt), 32'(tbl[i].exp_eg));
      chk($sformatf("tbl%0d_owner", i),   32'(a_if.o_owner),   32'(tbl[i].exp_own));
      tick();
    end
    drv_a(s0, s0);

    // MAX_BURST=1: alternating reads return to the right owner
    drv_b(mk(1'b1, 1'b0, 8'h01, 8'h00), mk(1'b1, 1'b0, 8'h02, 8'h00));
    #1;
    chk("alt1_cpu_gnt", 32'(b_if.o_cpu_gnt), 32'd1);
    chk("alt1_ext_gnt", 32'(b_if.o_ext_gnt), 32'd0);
    tick();
    drv_b(s0, mk(1'b1, 1'b0, 8'h02, 8'h00));
    #1;
    chk("alt2_ext_gnt",    32'(b_if.o_ext_gnt),    32'd1);
    chk("alt2_cpu_rvalid", 32'(b_if.o_cpu_rvalid), 32'd1);
    chk("alt2_cpu_rdata",  32'(b_if.o_cpu_rdata),  32'h11);
    chk("alt2_ext_rvalid", 32'(b_if.o_ext_rvalid), 32'd0);
    tick();
    drv_b(s0, s0);
    #1;
    chk("alt3_ext_rvalid", 32'(b_if.o_ext_rvalid), 32'd1);
    chk("alt3_ext_rdata",  32'(b_if.o_ext_rdata),  32'h22);
    chk("alt3_cpu_rvalid", 32'(b_if.o_cpu_rvalid), 32'd0);
    chk("alt3_cpu_rdata",  32'(b_if.o_cpu_rdata),  32'd0);
    tick();

    // MAX_BURST=1 with both requesting continuously: strict alternation
    for (int k = 0; k < 6; k++) begin
      drv_b(mk(1'b1, 1'b0, 8'h01, 8'h00), mk(1'b1, 1'b0, 8'h02, 8'h00));
      #1;
      chk($sformatf("b%0d_cpu_gnt", k),    32'(b_if.o_cpu_gnt),    32'(k % 2 == 0));
      chk($sformatf("b%0d_ext_gnt", k),    32'(b_if.o_ext_gnt),    32'(k % 2 == 1));
      chk($sformatf("b%0d_cpu_rvalid", k), 32'(b_if.o_cpu_rvalid), 32'(k % 2 == 1));
      chk($sformatf("b%0d_ext_rvalid", k), 32'(b_if.o_ext_rvalid), 32'(k > 0 && k % 2 == 0));
      chk($sformatf("b%0d_cpu_rdata", k),  32'(b_if.o_cpu_rdata),  (k % 2 == 1) ? 32'h11 : 32'h0);
      chk($sformatf("b%0d_ext_rdata", k),  32'(b_if.o_ext_rdata),  (k > 0 && k % 2 == 0) ? 32'h22 : 32'h0);
      tick();
    end
    drv_b(s0, s0);

    // Randomized traffic on instance A; requests held until granted
    cp = 1'b0; ep = 1'b0;
    cwe = 1'b0; ewe = 1'b0; caddr = '0; eaddr = '0; cwd = '0; ewd = '0;
    for (int k = 0; k < 400; k++) begin
      if (!cp && $urandom_range(0, 99) < 70) begin
        cp = 1'b1; cwe = 1'($urandom_range(0, 1));
        caddr = 8'($urandom_range(48, 63)); cwd = 8'($urandom);
      end
      if (!ep && $urandom_range(0, 99) < 70) begin
        ep = 1'b1; ewe = 1'($urandom_range(0, 1));
        eaddr = 8'($urandom_range(48, 63)); ewd = 8'($urandom);
      end
      rst = ($urandom_range(0, 99) < 2);
      drv_a(cp ? mk(1'b1, cwe, caddr, cwd) : mk(1'b0, 1'($urandom), 8'($urandom), 8'($urandom)),
            ep ? mk(1'b1, ewe, eaddr, ewd) : mk(1'b0, 1'($urandom), 8'($urandom), 8'($urandom)));
      #1;
      chk_model();
      g = model_grant();
      tick();
      if (g == 1) cp = 1'b0;
      if (g == 2) ep = 1'b0;
    end
    rst = 1'b0;
    drv_a(s0, s0);
    #1;
    chk_model();

`ifdef MEM_ARB_STATS_EN
    chk("stat_conflict", 32'(a_conf), 32'(m_conf));
    chk("stat_ext_gnt",  32'(a_egc),  32'(m_egc));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
